// File: rtl/hazard_halt_if.sv
// ID-stage hazard/halt bus: decoded ID fields in, pipeline write controls and status out.
interface hazard_halt_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_write_enable;
    logic             id_mem_read;
    logic             id_is_ecall;
    logic             halt_req;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             is_halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_enable, id_mem_read, id_is_ecall, halt_req,
        input  pc_write, if_id_write, id_ex_bubble, is_halted, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_enable, id_mem_read, id_is_ecall, halt_req,
        output pc_write, if_id_write, id_ex_bubble, is_halted, stall_count
    );
endinterface

// File: rtl/hazard_halt_controller.sv
// Load-use / ecall hazard stall, drain-and-halt sequencing, and a shadow EX/MEM/WB
// writer pipeline for a 5-stage core.
module hazard_halt_controller #(
    parameter int FORWARDING   = 1,
    parameter int WB_BYPASS    = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    hazard_halt_if.slave hz
);
    localparam int STAGES = 3;
    localparam int EX     = 0;
    localparam int MEM    = 1;
    localparam int WB     = 2;
    localparam int NSRC   = 3;   // rs1, rs2, x17 for the ecall compare
    localparam int DW     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       mem_read;
    } shadow_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                         state;
    shadow_t [STAGES-1:0]           shd;
    logic    [DW-1:0]               drain_cnt;
    logic    [CNT_W-1:0]            stall_cnt;
    logic                           halted_q;

    logic    [STAGES-1:0]           writer;
    logic    [NSRC-1:0][4:0]        src_reg;
    logic    [NSRC-1:0][STAGES-1:0] match;
    logic    [NSRC-1:0]             src_hz;
    logic                           ecall_hz;
    logic                           stall;
    logic                           advance;
    logic                           go_drain;

    assign src_reg[0] = hz.id_rs1;
    assign src_reg[1] = hz.id_rs2;
    assign src_reg[2] = 5'd17;

    for (genvar s = 0; s < STAGES; s++) begin : g_wr
        assign writer[s] = shd[s].valid && shd[s].we && (shd[s].rd != 5'd0);
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        for (genvar s = 0; s < STAGES; s++) begin : g_stg
            assign match[i][s] = writer[s] && (shd[s].rd == src_reg[i]);
        end
        // With bypassing only a load in EX is uncovered; without it every live writer counts.
        if (FORWARDING != 0) begin : g_fwd
            assign src_hz[i] = (src_reg[i] != 5'd0) && match[i][EX] && shd[EX].mem_read;
        end else begin : g_nofwd
            assign src_hz[i] = (src_reg[i] != 5'd0) &&
                               (match[i][EX] || match[i][MEM] ||
                                ((WB_BYPASS == 0) && match[i][WB]));
        end
    end

    // x17 is compared in ID, so EX results are never bypassable and MEM loads arrive too late.
    assign ecall_hz = match[2][EX] || (match[2][MEM] && shd[MEM].mem_read) ||
                      ((FORWARDING == 0) && src_hz[2]);

    assign stall = hz.id_valid && (state == RUN) &&
                   ((hz.id_use_rs1 && src_hz[0]) ||
                    (hz.id_use_rs2 && src_hz[1]) ||
                    (hz.id_is_ecall && ecall_hz));

    assign advance  = (state == RUN) && !stall;
    assign go_drain = advance && hz.id_valid && hz.id_is_ecall && hz.halt_req;

    assign hz.pc_write     = advance;
    assign hz.if_id_write  = advance;
    assign hz.id_ex_bubble = !advance;
    assign hz.is_halted    = halted_q;
    assign hz.stall_count  = stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            shd       <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            shd[WB]  <= shd[MEM];
            shd[MEM] <= shd[EX];
            // The terminating ecall itself never becomes an in-flight instruction.
            if (advance && !go_drain) begin
                shd[EX] <= '{valid: hz.id_valid, rd: hz.id_rd,
                             we: hz.id_write_enable, mem_read: hz.id_mem_read};
            end else begin
                shd[EX] <= '0;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            case (state)
                RUN: begin
                    if (go_drain) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end
endmodule
